// File: rtl/yu_mem_pkg.sv
// Shared definitions for the memory access unit: access size encodings,
// the controller state enum and a misalignment helper used when the
// MISALIGN_TRAP_EN build option is enabled.
package yu_mem_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_e;

  // Returns 1 when an access of the given size cannot be served at the
  // given low address bits (reserved size counts as misaligned).
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the memory access unit: extracts and
// sign/zero-extends load data from a RAM word, and merges sub-word store
// data into a previously read word.
module mem_lane_align
  import yu_mem_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [WORD_W-1:0] rdata_i,
  input  logic [WORD_W-1:0] old_word_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] load_data_o,
  output logic [WORD_W-1:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Pick the addressed lane of the read word and extend it to a full word;
  // half lanes only look at addr[1], so an odd half address is folded down.
  always_comb begin
    byte_v      = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_v      = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_data_o = rdata_i;
    case (size_i)
      SZ_BYTE: load_data_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      SZ_HALF: load_data_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_data_o = rdata_i;
    endcase
  end

  // Overwrite only the addressed lane of the old word with the low store bits.
  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]  = wdata_i[7:0];
      SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory access unit: accepts one core load/store at a time and drives a
// word-organised RAM (combinational read, posedge write). Byte and half
// stores are done as read-modify-write. Build option MISALIGN_TRAP_EN turns
// misaligned or reserved-size requests into immediate error responses;
// without it the offending low address bits are ignored and size 3 is a word.
module mem_access_unit
  import yu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q, state_d;
  state_e                route_st;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  uns_q, uns_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] rmw_q, rmw_d;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged_word;
`ifdef MISALIGN_TRAP_EN
  logic                  err_q, err_d;
`endif

  mem_lane_align u_align (
    .addr_lo_i   (addr_q[1:0]),
    .size_i      (size_q),
    .unsigned_i  (uns_q),
    .rdata_i     (mem_rdata),
    .old_word_i  (rmw_q),
    .wdata_i     (wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged_word)
  );

  // Choose the first working state for an incoming request; size 2 and 3
  // both store a full word, smaller stores need a read first.
  always_comb begin
    route_st = LOAD;
    if (req_we) begin
      route_st = req_size[1] ? STORE : RMW_RD;
    end
  end

  // Register all state; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      rmw_q   <= '0;
`ifdef MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rmw_q   <= rmw_d;
`ifdef MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and output decode; RAM strobes come straight from the state.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    we_d       = we_q;
    uns_d      = uns_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rmw_d      = rmw_q;
`ifdef MISALIGN_TRAP_EN
    err_d      = err_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          we_d    = req_we;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
`ifdef MISALIGN_TRAP_EN
          err_d   = is_misaligned(req_size, req_addr[1:0]);
          state_d = err_d ? RESP : route_st;
`else
          state_d = route_st;
`endif
        end
      end
      LOAD: begin
        mem_re  = 1'b1;
        rdata_d = load_data;
        state_d = RESP;
      end
      STORE: begin
        mem_we    = 1'b1;
        mem_wdata = wdata_q;
        state_d   = RESP;
      end
      RMW_RD: begin
        mem_re  = 1'b1;
        rmw_d   = mem_rdata;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merged_word;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign resp_rdata = rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign resp_err   = resp_valid & err_q;
`else
  assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a word RAM model, a behavioural reference
// of loads/stores, directed scenarios with literal expectations and a
// randomized transaction stream. Honours MISALIGN_TRAP_EN like the design.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic [31:0] ram  [0:63];
  logic [31:0] gold [0:63];

  int          testsRun = 0;
  int          failures = 0;
  int          cycleCnt = 0;
  int          weCount = 0;
  int          acceptCycle;
  int          pendLat;
  int          lastLat;
  bit          lastErr;
  bit          pending;
  bit          pendErr;
  bit          monitorOn;
  logic [31:0] heldRdata;
  logic [31:0] pendRdata;
  logic [31:0] pendWord;
  logic [31:0] pendAddr;
  logic [7:0]  trace;
  logic [7:0]  pendTrace;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word RAM with combinational read and posedge write.
  assign mem_rdata = ram[mem_addr[7:2]];

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (mem_we) begin
      ram[mem_addr[7:2]] <= mem_wdata;
      weCount <= weCount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at time %0t", name, actual, expected, $time);
    end
  endtask

  // Reference load: pick the lane by byte offset and extend it.
  function automatic logic [31:0] modelLoad(input logic [31:0] w, input int a, input int sz, input bit uns);
    int sh;
    logic [31:0] v;
    if (sz == 0) begin
      sh = (a % 4) * 8;
      v = (w >> sh) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      sh = ((a / 2) % 2) * 16;
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  // Reference store: mask out the target lane and OR in the new bits.
  function automatic logic [31:0] modelMerge(input logic [31:0] w, input int a, input int sz, input logic [31:0] wd);
    int sh;
    logic [31:0] mask;
    if (sz == 0) begin
      sh = (a % 4) * 8;
      mask = 32'hFF << sh;
      return (w & ~mask) | ((wd & 32'hFF) << sh);
    end else if (sz == 1) begin
      sh = ((a / 2) % 2) * 16;
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  // Compare process: checks every cycle against the expected transaction.
  always @(negedge clk) begin
    if (monitorOn && rst_n) begin
      checkOutput("re_we_exclusive", {31'b0, mem_re & mem_we}, 32'h0);
      if (!pending) begin
        checkOutput("idle_ctrl", {28'b0, resp_valid, resp_err, mem_re, mem_we}, 32'h0);
        checkOutput("idle_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rdata_hold", resp_rdata, heldRdata);
      end else begin
        trace = {trace[5:0], mem_re, mem_we};
        checkOutput("busy_ready", {31'b0, req_ready}, 32'h0);
        if (mem_re || mem_we) checkOutput("mem_addr", mem_addr, pendAddr & 32'hFFFF_FFFC);
        if (mem_we) checkOutput("mem_wdata", mem_wdata, pendWord);
        if (resp_valid) begin
          lastLat = cycleCnt - acceptCycle + 1;
          lastErr = resp_err;
          checkOutput("resp_latency", lastLat, pendLat);
          checkOutput("resp_err", {31'b0, resp_err}, {31'b0, pendErr});
          checkOutput("resp_rdata", resp_rdata, pendRdata);
          checkOutput("mem_trace", {24'b0, trace}, {24'b0, pendTrace});
          heldRdata = pendRdata;
          pending = 1'b0;
        end else begin
          checkOutput("rdata_hold_busy", resp_rdata, heldRdata);
        end
      end
    end
  end

  // Issue one request, compute its expected outcome and wait for completion.
  task automatic applyStimulus(input logic [7:0] a, input logic [1:0] sz, input bit we, input bit uns, input logic [31:0] wd);
    int n;
    int idx;
    int effSz;
    bit trap;
    @(negedge clk);
    req_addr     = {24'b0, a};
    req_size     = sz;
    req_we       = we;
    req_unsigned = uns;
    req_wdata    = wd;
    req_valid    = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      return;
    end
    idx = int'(a) / 4;
`ifdef MISALIGN_TRAP_EN
    trap = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00) || sz == 2'd3;
`else
    trap = 1'b0;
`endif
    effSz     = (sz == 2'd3) ? 2 : int'(sz);
    pendAddr  = {24'b0, a};
    pendErr   = trap;
    pendRdata = heldRdata;
    pendWord  = 32'h0;
    if (trap) begin
      pendLat = 1;
      pendTrace = 8'h00;
    end else if (!we) begin
      pendLat = 2;
      pendTrace = 8'h08;
      pendRdata = modelLoad(gold[idx], int'(a), effSz, uns);
    end else begin
      pendWord = modelMerge(gold[idx], int'(a), effSz, wd);
      gold[idx] = pendWord;
      pendLat = (effSz == 2) ? 2 : 3;
      pendTrace = (effSz == 2) ? 8'h04 : 8'h24;
    end
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_size     = 2'($urandom_range(0, 3));
    req_we       = 1'($urandom_range(0, 1));
    req_unsigned = 1'($urandom_range(0, 1));
    req_wdata    = $urandom;
    acceptCycle  = cycleCnt;
    trace        = 8'h00;
    pending      = 1'b1;
    n = 0;
    while (pending && n < 10) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (pending) begin
      checkOutput("resp_timeout", 32'h0, 32'h1);
      pending = 1'b0;
    end
    checkOutput("ram_word", ram[idx], gold[idx]);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    ram[idx]  = v;
    gold[idx] = v;
  endtask

  // Byte store that is interrupted by reset while reading the old word.
  task automatic resetMidRmw();
    int weBefore;
    preload(5, 32'hCAFE_F00D);
    @(negedge clk);
    req_addr     = 32'h15;
    req_size     = 2'd0;
    req_we       = 1'b1;
    req_unsigned = 1'b0;
    req_wdata    = 32'h5A;
    req_valid    = 1'b1;
    checkOutput("rmw_pre_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    monitorOn = 1'b0;
    weBefore  = weCount;
    @(negedge clk);
    checkOutput("rmw_rd_re", {30'b0, mem_re, mem_we}, 32'h2);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ctrl", {28'b0, resp_valid, resp_err, mem_re, mem_we}, 32'h0);
    checkOutput("rst_mid_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mid_addr", mem_addr, 32'h0);
    checkOutput("rst_mid_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    heldRdata = 32'h0;
    @(negedge clk);
    checkOutput("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    checkOutput("rst_mid_no_we", weCount, weBefore);
    checkOutput("rst_mid_ram", ram[5], 32'hCAFE_F00D);
    monitorOn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    monitorOn    = 1'b0;
    pending      = 1'b0;
    heldRdata    = 32'h0;
    trace        = 8'h00;
    for (int i = 0; i < 64; i++) begin
      ram[i]  = $urandom;
      gold[i] = ram[i];
    end

    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_ctrl", {28'b0, resp_valid, resp_err, mem_re, mem_we}, 32'h0);
      checkOutput("reset_rdata", resp_rdata, 32'h0);
      checkOutput("reset_addr", mem_addr, 32'h0);
      checkOutput("reset_wdata", mem_wdata, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'b0, req_ready}, 32'h1);
    monitorOn = 1'b1;

    applyStimulus(8'h10, 2'd2, 1'b1, 1'b0, 32'hDEAD_BEEF);
    checkOutput("lit_word_store_ram", ram[4], 32'hDEAD_BEEF);
    checkOutput("lit_word_store_lat", lastLat, 32'd2);
    applyStimulus(8'h10, 2'd2, 1'b0, 1'b0, 32'h0);
    checkOutput("lit_word_load_data", resp_rdata, 32'hDEAD_BEEF);
    checkOutput("lit_word_load_lat", lastLat, 32'd2);

    preload(4, 32'h1122_3344);
    applyStimulus(8'h12, 2'd0, 1'b1, 1'b0, 32'h1234_56AA);
    checkOutput("lit_byte_rmw_ram", ram[4], 32'h11AA_3344);
    checkOutput("lit_byte_rmw_lat", lastLat, 32'd3);

    preload(4, 32'h80FF_7F01);
    applyStimulus(8'h12, 2'd1, 1'b0, 1'b0, 32'h0);
    checkOutput("lit_half_signed", resp_rdata, 32'hFFFF_80FF);
    applyStimulus(8'h11, 2'd0, 1'b0, 1'b1, 32'h0);
    checkOutput("lit_byte_unsigned", resp_rdata, 32'h0000_007F);

    applyStimulus(8'h13, 2'd2, 1'b0, 1'b0, 32'h0);
`ifdef MISALIGN_TRAP_EN
    checkOutput("lit_misalign_err", {31'b0, lastErr}, 32'h1);
    checkOutput("lit_misalign_lat", lastLat, 32'd1);
    checkOutput("lit_misalign_rdata", resp_rdata, 32'h0000_007F);
`else
    checkOutput("lit_misalign_err", {31'b0, lastErr}, 32'h0);
    checkOutput("lit_misalign_lat", lastLat, 32'd2);
    checkOutput("lit_misalign_rdata", resp_rdata, 32'h80FF_7F01);
`endif

    resetMidRmw();

    for (int t = 0; t < 300; t++) begin
      applyStimulus(8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int i = 0; i < 64; i++) begin
      checkOutput("final_ram", ram[i], gold[i]);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
